// File: rtl/pipe_in_verify.sv
// Checks incoming pipe words against a Count or LFSR reference sequence and tracks a throttled virtual FIFO level.
// Optional first-mismatch capture registers are enabled by defining PIPE_IN_VERIFY_ERRCAP_EN.
module pipe_in_verify (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_in_write,
  input  logic [15:0] pipe_in_data,
  output logic        pipe_in_ready,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  input  logic        mode,
  output logic [31:0] word_count,
  output logic [31:0] error_count,
  output logic [1:0]  status,
  output logic [31:0] first_err_index,
  output logic [15:0] first_err_expected,
  output logic [15:0] first_err_received
);

  localparam int unsigned SEQ_W       = 32;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned LVL_W       = 16;
  localparam int unsigned READY_LIMIT = 1024;
  localparam logic [SEQ_W-1:0] COUNT_SEED = 32'h0000_0001;
  localparam logic [SEQ_W-1:0] LFSR_SEED  = 32'h0403_0201;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               mode_q;
  logic [SEQ_W-1:0]   seq;
  logic [SEQ_W-1:0]   seq_next_c;
  logic [LVL_W-1:0]   level;
  logic [SEQ_W-1:0]   throttle;
  logic               mismatch_c;

  assign mismatch_c = (pipe_in_data != seq[DATA_W-1:0]);
  assign seq_next_c = mode_q ? {seq[SEQ_W-2:0], seq[31] ^ seq[21] ^ seq[1]}
                             : seq + SEQ_W'(1);
  assign status     = state;

  // Status FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Status FSM next state: ERR is sticky until reset
  always_comb begin
    state_next = state;
    if (pipe_in_write) begin
      case (state)
        ST_IDLE: state_next = mismatch_c ? ST_ERR : ST_RUN;
        ST_RUN:  if (mismatch_c) state_next = ST_ERR;
        default: state_next = ST_ERR;
      endcase
    end
  end

  // Sequence state and saturating counters; mode only latched in reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q      <= mode;
      seq         <= mode ? LFSR_SEED : COUNT_SEED;
      word_count  <= '0;
      error_count <= '0;
    end else if (pipe_in_write) begin
      seq <= seq_next_c;
      if (word_count != '1) word_count <= word_count + CNT_W'(1);
      if (mismatch_c && (error_count != '1)) error_count <= error_count + CNT_W'(1);
    end
  end

  // Virtual FIFO level, drain throttle and registered ready
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level         <= '0;
      throttle      <= throttle_val;
      pipe_in_ready <= 1'b0;
    end else begin
      pipe_in_ready <= (level < LVL_W'(READY_LIMIT));
      case ({pipe_in_write, throttle[0]})
        2'b10:   if (level != '1) level <= level + LVL_W'(1);
        2'b01:   if (level != '0) level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (throttle_set) throttle <= throttle_val;
      else              throttle <= {throttle[0], throttle[SEQ_W-1:1]};
    end
  end

`ifdef PIPE_IN_VERIFY_ERRCAP_EN
  // Capture the first mismatch since reset; word_count is the pre-increment index
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_err_index    <= '0;
      first_err_expected <= '0;
      first_err_received <= '0;
    end else if (pipe_in_write && mismatch_c && (state != ST_ERR)) begin
      first_err_index    <= word_count;
      first_err_expected <= seq[DATA_W-1:0];
      first_err_received <= pipe_in_data;
    end
  end
`else
  assign first_err_index    = '0;
  assign first_err_expected = '0;
  assign first_err_received = '0;
`endif

endmodule

// File: tb/tb_pipe_in_verify.sv
// Self-checking bench for pipe_in_verify: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_in_verify;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_in_write;
  logic [15:0] pipe_in_data;
  logic        pipe_in_ready;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic        mode;
  logic [31:0] word_count;
  logic [31:0] error_count;
  logic [1:0]  status;
  logic [31:0] first_err_index;
  logic [15:0] first_err_expected;
  logic [15:0] first_err_received;

  int checks = 0;
  int errors = 0;

  pipe_in_verify dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .pipe_in_write      (pipe_in_write),
    .pipe_in_data       (pipe_in_data),
    .pipe_in_ready      (pipe_in_ready),
    .throttle_set       (throttle_set),
    .throttle_val       (throttle_val),
    .mode               (mode),
    .word_count         (word_count),
    .error_count        (error_count),
    .status             (status),
    .first_err_index    (first_err_index),
    .first_err_expected (first_err_expected),
    .first_err_received (first_err_received)
  );

  always #5 clk = ~clk;

  // Reference model: write index since reset, LFSR word, plain integer counters
  bit               m_mode;
  longint unsigned  m_idx;
  logic [31:0]      m_lfsr;
  longint unsigned  m_wc, m_ec;
  int               m_status;
  int               m_level;
  bit               m_ready;
  logic [31:0]      m_thr;
  bit               m_have_err;
  logic [31:0]      m_ci;
  logic [15:0]      m_ce, m_cr;

  function automatic logic [15:0] expected_word();
    if (!m_mode) return 16'(m_idx + 1);
    return m_lfsr[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready", 32'(pipe_in_ready), 32'(m_ready));
    chk("word_count", word_count, 32'(m_wc));
    chk("error_count", error_count, 32'(m_ec));
    chk("status", 32'(status), 32'(m_status));
`ifdef PIPE_IN_VERIFY_ERRCAP_EN
    chk("cap_index", first_err_index, m_ci);
    chk("cap_expected", 32'(first_err_expected), 32'(m_ce));
    chk("cap_received", 32'(first_err_received), 32'(m_cr));
`else
    chk("cap_index", first_err_index, 32'd0);
    chk("cap_expected", 32'(first_err_expected), 32'd0);
    chk("cap_received", 32'(first_err_received), 32'd0);
`endif
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later
  task automatic cycle(input bit w, input logic [15:0] d, input bit ts,
                       input logic [31:0] tv, input bit rn);
    logic [15:0] exp;
    pipe_in_write = w;
    pipe_in_data  = d;
    throttle_set  = ts;
    throttle_val  = tv;
    reset_n       = rn;
    @(posedge clk);
    if (!rn) begin
      m_mode = mode; m_idx = 0; m_lfsr = 32'h0403_0201;
      m_wc = 0; m_ec = 0; m_status = 0; m_level = 0; m_ready = 0;
      m_thr = tv; m_have_err = 0; m_ci = 0; m_ce = 0; m_cr = 0;
    end else begin
      m_ready = (m_level < 1024);
      if (w && !m_thr[0]) m_level = (m_level < 65535) ? m_level + 1 : 65535;
      else if (!w && m_thr[0]) m_level = (m_level > 0) ? m_level - 1 : 0;
      m_thr = ts ? tv : {m_thr[0], m_thr[31:1]};
      if (w) begin
        exp = expected_word();
        if (d !== exp) begin
          if (!m_have_err) begin
            m_ci = 32'(m_wc); m_ce = exp; m_cr = d;
          end
          m_have_err = 1;
          if (m_ec < 64'hFFFF_FFFF) m_ec++;
          m_status = 2;
        end else if (m_status == 0) begin
          m_status = 1;
        end
        if (m_wc < 64'hFFFF_FFFF) m_wc++;
        m_idx++;
        m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1]};
      end
    end
    #1;
    check_all();
  endtask

  task automatic wr(input logic [15:0] d);
    cycle(1'b1, d, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic rst(input bit md, input logic [31:0] tv);
    mode = md;
    cycle(1'b0, 16'd0, 1'b0, tv, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    mode = 1'b0;

    // Reset values
    rst(1'b0, 32'd0);
    rst(1'b0, 32'd0);
    chk("rst_ready", 32'(pipe_in_ready), 32'd0);
    chk("rst_wc", word_count, 32'd0);
    chk("rst_status", 32'(status), 32'd0);

    // Count mode, 16 good words
    for (int i = 1; i <= 16; i++) wr(16'(i));
    chk("cnt16_wc", word_count, 32'd16);
    chk("cnt16_ec", error_count, 32'd0);
    chk("cnt16_status", 32'(status), 32'd1);

    // Single corrupted word in Count mode
    rst(1'b0, 32'd0);
    wr(16'h0001); wr(16'h0002); wr(16'h00FF); wr(16'h0004);
    chk("bad_ec", error_count, 32'd1);
    chk("bad_wc", word_count, 32'd4);
    chk("bad_status", 32'(status), 32'd2);
`ifdef PIPE_IN_VERIFY_ERRCAP_EN
    chk("bad_index", first_err_index, 32'd2);
    chk("bad_expected", 32'(first_err_expected), 32'h0003);
    chk("bad_received", 32'(first_err_received), 32'h00FF);
`endif

    // Reset with write asserted, then restart from seed
    cycle(1'b1, 16'h0001, 1'b0, 32'd0, 1'b0);
    chk("rstw_wc", word_count, 32'd0);
    chk("rstw_ec", error_count, 32'd0);
    chk("rstw_status", 32'(status), 32'd0);
    wr(16'h0001);
    chk("restart_ec", error_count, 32'd0);
    chk("restart_status", 32'(status), 32'd1);

    // LFSR mode sequence
    rst(1'b1, 32'd0);
    wr(16'h0201); wr(16'h0402); wr(16'h0805);
    chk("lfsr_ec", error_count, 32'd0);
    chk("lfsr_status", 32'(status), 32'd1);
    wr(16'h0000);
    chk("lfsr_bad_ec", error_count, 32'd1);
    chk("lfsr_bad_status", 32'(status), 32'd2);

    // Mode change outside reset is ignored
    rst(1'b0, 32'd0);
    mode = 1'b1;
    wr(16'h0001); wr(16'h0002);
    chk("modechg_ec", error_count, 32'd0);
    mode = 1'b0;

    // Fill to 1024 with no drain, then drain with all-ones throttle
    rst(1'b0, 32'd0);
    for (int i = 1; i <= 1024; i++) wr(16'(i));
    chk("fill_ready_last", 32'(pipe_in_ready), 32'd1);
    idle();
    chk("fill_ready_low", 32'(pipe_in_ready), 32'd0);
    for (int i = 1025; i <= 1028; i++) wr(16'(i));
    chk("notready_wc", word_count, 32'd1028);
    chk("notready_ec", error_count, 32'd0);
    cycle(1'b0, 16'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      idle();
      if (m_level == 1023) found = 1;
    end
    chk("drain_reached", 32'(found), 32'd1);
    chk("drain_ready_still_low", 32'(pipe_in_ready), 32'd0);
    idle();
    chk("drain_ready_high", 32'(pipe_in_ready), 32'd1);

    // Randomized traffic against the model, with occasional mid-run resets
    for (int r = 0; r < 6; r++) begin
      rst(1'($urandom_range(0, 1)), $urandom);
      for (int i = 0; i < 300; i++) begin
        bit w, ts;
        logic [15:0] d;
        mode = 1'($urandom_range(0, 1));
        w  = ($urandom_range(0, 99) < 60);
        ts = ($urandom_range(0, 99) < 5);
        d  = ($urandom_range(0, 99) < 92) ? expected_word() : 16'($urandom);
        if ($urandom_range(0, 199) == 0) cycle(w, d, ts, $urandom, 1'b0);
        else                              cycle(w, d, ts, $urandom, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
